acumulador_productos: RTL and testbench

- Downstream consumer of the 64-bit cascaded multiplier stage; sits directly after it.
- Accepts each finished product over the Done_Flag/ack 4-phase handshake.
- Accumulates a batch of COUNT products into a wide sum.
- Presents the sum to the next consumer over a second 4-phase handshake (sum_valid/sum_ack), with a sticky overflow flag.

---
 rtl/acumulador_productos.sv | 141 ++++++++++++++
 tb/tb_acumulador_productos.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_productos.sv
// acumulador_productos
//
// Collects a batch of COUNT products from the multiplier stage and hands the
// batch sum to the next consumer.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   producto   product from the multiplier stage (WIDTH bits)
//   Done_Flag  producer request, producto valid while high
//   ack        acknowledge back to the multiplier stage
//   suma       running sum of the current batch (ACC_WIDTH bits)
//   cuenta     products accepted in the current batch (COUNT_W bits)
//   sum_valid  batch sum ready for downstream
//   sum_ack    downstream acknowledge
//   overflow   sticky: the accumulator wrapped during the current batch
//   estado     current FSM state, for observation only
//
// Handshakes: both sides are 4-phase. Upstream, a product is taken once when
// Done_Flag is sampled high in ESPERA, ack rises on the next edge and stays
// high until Done_Flag is sampled low; no new product is taken before ack has
// fallen. Downstream, sum_valid stays high until sum_ack is sampled high, and
// the batch is cleared only after sum_ack is sampled low again. sum_ack is
// ignored in ESPERA/ACK, Done_Flag is ignored in SALIDA/DRENAJE.

module acumulador_productos #(
    parameter int WIDTH     = 64,
    parameter int ACC_WIDTH = 72,
    parameter int COUNT     = 4,
    parameter int COUNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     producto,
    input  logic                 Done_Flag,
    output logic                 ack,
    output logic [ACC_WIDTH-1:0] suma,
    output logic [COUNT_W-1:0]   cuenta,
    output logic                 sum_valid,
    input  logic                 sum_ack,
    output logic                 overflow,
    output logic [1:0]           estado
);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ACK     = 2'd1,
        SALIDA  = 2'd2,
        DRENAJE = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic                   ack_n;
    logic                   sum_valid_n;
    logic [ACC_WIDTH-1:0]   suma_n;
    logic [COUNT_W-1:0]     cuenta_n;
    logic                   overflow_n;

    // One spare bit on top of the accumulator catches the carry out of the
    // modular add; it feeds the sticky overflow flag.
    logic [ACC_WIDTH:0]     sum_ext;

    assign sum_ext = {1'b0, suma} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, producto};
    assign estado  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ESPERA;
            ack       <= 1'b0;
            sum_valid <= 1'b0;
            suma      <= '0;
            cuenta    <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            ack       <= ack_n;
            sum_valid <= sum_valid_n;
            suma      <= suma_n;
            cuenta    <= cuenta_n;
            overflow  <= overflow_n;
        end
    end

    always_comb begin
        state_n     = state;
        ack_n       = ack;
        sum_valid_n = sum_valid;
        suma_n      = suma;
        cuenta_n    = cuenta;
        overflow_n  = overflow;

        case (state)
            ESPERA: begin
                if (Done_Flag) begin
                    suma_n   = sum_ext[ACC_WIDTH-1:0];
                    cuenta_n = cuenta + COUNT_W'(1);
                    ack_n    = 1'b1;
                    state_n  = ACK;
                    if (sum_ext[ACC_WIDTH]) begin
                        overflow_n = 1'b1;
                    end
                end
            end

            ACK: begin
                // A long Done_Flag is one product: nothing accumulates here.
                if (!Done_Flag) begin
                    ack_n = 1'b0;
                    if (cuenta == COUNT_W'(COUNT)) begin
                        sum_valid_n = 1'b1;
                        state_n     = SALIDA;
                    end else begin
                        state_n = ESPERA;
                    end
                end
            end

            SALIDA: begin
                if (sum_ack) begin
                    sum_valid_n = 1'b0;
                    state_n     = DRENAJE;
                end
            end

            DRENAJE: begin
                // The batch is kept visible until downstream releases sum_ack.
                if (!sum_ack) begin
                    suma_n     = '0;
                    cuenta_n   = '0;
                    overflow_n = 1'b0;
                    state_n    = ESPERA;
                end
            end

            default: begin
                state_n = ESPERA;
            end
        endcase
    end

endmodule

// File: tb/tb_acumulador_productos.sv
// Bench for acumulador_productos: three instances (default, ACC_WIDTH=64 for
// wrap-around, COUNT=1), a handshake-level reference model checked every
// cycle, and hand-computed literal checks for the directed scenarios.

module tb_acumulador_productos;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [2:0]        done_v;
    logic [2:0]        sack_v;
    logic [2:0]        ack_v;
    logic [2:0]        sv_v;
    logic [2:0]        ovf_v;
    logic [63:0]       prod_v [3];
    logic [71:0]       suma0;
    logic [63:0]       suma1;
    logic [71:0]       suma2;
    logic [7:0]        cnt_v [3];
    logic [1:0]        est_v [3];

    int n_checks = 0;
    int n_err    = 0;

    int acc_w   [3] = '{72, 64, 72};
    int cnt_lim [3] = '{4, 4, 1};

    acumulador_productos #(.WIDTH(64), .ACC_WIDTH(72), .COUNT(4), .COUNT_W(8)) u_main (
        .clk(clk), .reset(rst_n), .producto(prod_v[0]), .Done_Flag(done_v[0]),
        .ack(ack_v[0]), .suma(suma0), .cuenta(cnt_v[0]), .sum_valid(sv_v[0]),
        .sum_ack(sack_v[0]), .overflow(ovf_v[0]), .estado(est_v[0])
    );

    acumulador_productos #(.WIDTH(64), .ACC_WIDTH(64), .COUNT(4), .COUNT_W(8)) u_wrap (
        .clk(clk), .reset(rst_n), .producto(prod_v[1]), .Done_Flag(done_v[1]),
        .ack(ack_v[1]), .suma(suma1), .cuenta(cnt_v[1]), .sum_valid(sv_v[1]),
        .sum_ack(sack_v[1]), .overflow(ovf_v[1]), .estado(est_v[1])
    );

    acumulador_productos #(.WIDTH(64), .ACC_WIDTH(72), .COUNT(1), .COUNT_W(8)) u_one (
        .clk(clk), .reset(rst_n), .producto(prod_v[2]), .Done_Flag(done_v[2]),
        .ack(ack_v[2]), .suma(suma2), .cuenta(cnt_v[2]), .sum_valid(sv_v[2]),
        .sum_ack(sack_v[2]), .overflow(ovf_v[2]), .estado(est_v[2])
    );

    function automatic logic [127:0] get_suma(int i);
        case (i)
            0:       return {56'b0, suma0};
            1:       return {64'b0, suma1};
            default: return {56'b0, suma2};
        endcase
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (handshake phases) ----------------
    logic [127:0] m_sum   [3];
    int           m_cnt   [3];
    logic         m_ack   [3];
    logic         m_sv    [3];
    logic         m_drain [3];
    logic         m_ovf   [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_sum[i] <= '0; m_cnt[i] <= 0; m_ack[i] <= 1'b0;
                m_sv[i] <= 1'b0; m_drain[i] <= 1'b0; m_ovf[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_ack[i]) begin
                    // producer must release its request before anything else
                    if (!done_v[i]) begin
                        m_ack[i] <= 1'b0;
                        if (m_cnt[i] == cnt_lim[i]) m_sv[i] <= 1'b1;
                    end
                end else if (m_sv[i]) begin
                    if (sack_v[i]) begin
                        m_sv[i]    <= 1'b0;
                        m_drain[i] <= 1'b1;
                    end
                end else if (m_drain[i]) begin
                    if (!sack_v[i]) begin
                        m_drain[i] <= 1'b0;
                        m_sum[i]   <= '0;
                        m_cnt[i]   <= 0;
                        m_ovf[i]   <= 1'b0;
                    end
                end else if (done_v[i]) begin
                    if (((m_sum[i] + {64'b0, prod_v[i]}) >> acc_w[i]) != 0) m_ovf[i] <= 1'b1;
                    m_sum[i] <= (m_sum[i] + {64'b0, prod_v[i]}) & ((128'd1 << acc_w[i]) - 128'd1);
                    m_cnt[i] <= m_cnt[i] + 1;
                    m_ack[i] <= 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("i%0d model ack", i), {127'b0, ack_v[i]}, {127'b0, m_ack[i]});
                chk($sformatf("i%0d model sum_valid", i), {127'b0, sv_v[i]}, {127'b0, m_sv[i]});
                chk($sformatf("i%0d model overflow", i), {127'b0, ovf_v[i]}, {127'b0, m_ovf[i]});
                chk($sformatf("i%0d model cuenta", i), {120'b0, cnt_v[i]}, 128'(m_cnt[i]));
                chk($sformatf("i%0d model suma", i), get_suma(i), m_sum[i]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack_low(int i);
        for (int k = 0; k < 20 && ack_v[i] !== 1'b0; k++) @(negedge clk);
        chk($sformatf("i%0d ack release", i), {127'b0, ack_v[i]}, 128'd0);
    endtask

    task automatic send(int i, logic [63:0] v);
        prod_v[i] = v;
        done_v[i] = 1'b1;
        @(negedge clk);
        chk($sformatf("i%0d ack latency", i), {127'b0, ack_v[i]}, 128'd1);
        done_v[i] = 1'b0;
        wait_ack_low(i);
    endtask

    task automatic drain(int i, int hold);
        sack_v[i] = 1'b1;
        @(negedge clk);
        chk($sformatf("i%0d sum_valid fall", i), {127'b0, sv_v[i]}, 128'd0);
        repeat (hold - 1) @(negedge clk);
        sack_v[i] = 1'b0;
        @(negedge clk);
        chk($sformatf("i%0d suma clear", i), get_suma(i), 128'd0);
        chk($sformatf("i%0d cuenta clear", i), {120'b0, cnt_v[i]}, 128'd0);
        chk($sformatf("i%0d overflow clear", i), {127'b0, ovf_v[i]}, 128'd0);
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        done_v = '0;
        sack_v = '0;
        for (int i = 0; i < 3; i++) prod_v[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset ack", {125'b0, ack_v}, 128'd0);
        chk("reset sum_valid", {125'b0, sv_v}, 128'd0);
        chk("reset suma", get_suma(0), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // batch of four 1000s
        repeat (4) send(0, 64'd1000);
        chk("b1 sum_valid", {127'b0, sv_v[0]}, 128'd1);
        chk("b1 suma", get_suma(0), 128'd4000);
        chk("b1 cuenta", {120'b0, cnt_v[0]}, 128'd4);
        chk("b1 overflow", {127'b0, ovf_v[0]}, 128'd0);

        // producer requests during SALIDA/DRENAJE, sum_ack held 3 cycles
        prod_v[0] = 64'd7;
        done_v[0] = 1'b1;
        sack_v[0] = 1'b1;
        @(negedge clk);
        chk("drain sum_valid fall", {127'b0, sv_v[0]}, 128'd0);
        chk("drain ack blocked 1", {127'b0, ack_v[0]}, 128'd0);
        @(negedge clk);
        chk("drain ack blocked 2", {127'b0, ack_v[0]}, 128'd0);
        chk("drain suma frozen", get_suma(0), 128'd4000);
        @(negedge clk);
        chk("drain ack blocked 3", {127'b0, ack_v[0]}, 128'd0);
        sack_v[0] = 1'b0;
        @(negedge clk);
        chk("drain suma clear", get_suma(0), 128'd0);
        chk("drain cuenta clear", {120'b0, cnt_v[0]}, 128'd0);
        chk("drain ack still low", {127'b0, ack_v[0]}, 128'd0);

        // held request counts once
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold ack", {127'b0, ack_v[0]}, 128'd1);
            chk("hold suma", get_suma(0), 128'd7);
            chk("hold cuenta", {120'b0, cnt_v[0]}, 128'd1);
        end
        done_v[0] = 1'b0;
        wait_ack_low(0);

        // clean start, then asynchronous reset mid-handshake
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 64'd1000);
        prod_v[0] = 64'd1000;
        done_v[0] = 1'b1;
        @(negedge clk);
        chk("pre-reset ack", {127'b0, ack_v[0]}, 128'd1);
        chk("pre-reset suma", get_suma(0), 128'd2000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async ack", {127'b0, ack_v[0]}, 128'd0);
        chk("async sum_valid", {127'b0, sv_v[0]}, 128'd0);
        chk("async suma", get_suma(0), 128'd0);
        chk("async cuenta", {120'b0, cnt_v[0]}, 128'd0);
        done_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // mixed batch, sum_ack outside SALIDA ignored, crosses bit 64
        sack_v[0] = 1'b1;
        send(0, 64'd3);
        sack_v[0] = 1'b0;
        send(0, 64'd100);
        send(0, 64'hFFFF_FFFF_FFFF_FFFF);
        send(0, 64'd42);
        chk("b2 sum_valid", {127'b0, sv_v[0]}, 128'd1);
        chk("b2 suma", get_suma(0), 128'h01_0000_0000_0000_0090);
        chk("b2 overflow", {127'b0, ovf_v[0]}, 128'd0);
        drain(0, 1);

        // 64-bit accumulator wraps
        send(1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap ovf low", {127'b0, ovf_v[1]}, 128'd0);
        send(1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap ovf set", {127'b0, ovf_v[1]}, 128'd1);
        chk("wrap suma 2", get_suma(1), 128'hFFFF_FFFF_FFFF_FFFE);
        send(1, 64'hFFFF_FFFF_FFFF_FFFF);
        send(1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap suma 4", get_suma(1), 128'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap ovf sticky", {127'b0, ovf_v[1]}, 128'd1);
        chk("wrap sum_valid", {127'b0, sv_v[1]}, 128'd1);
        drain(1, 2);

        // COUNT=1
        send(2, 64'd12345);
        chk("one sum_valid", {127'b0, sv_v[2]}, 128'd1);
        chk("one suma", get_suma(2), 128'd12345);
        chk("one cuenta", {120'b0, cnt_v[2]}, 128'd1);
        drain(2, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
